// File: rtl/pad_stream_pkg.sv
// Shared helpers for the pad stream bridge: width-safe clog2, bit mirroring,
// default pin/word widths and the serialiser state type.
package pad_stream_pkg;

    localparam int DEF_PIN_IN_W   = 8;
    localparam int DEF_WORD_IN_W  = 32;
    localparam int DEF_PIN_OUT_W  = 16;
    localparam int DEF_WORD_OUT_W = 32;
    localparam int MIRROR_MAX_W   = 64;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    // Never returns less than 1 so degenerate counters still get a real bit.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MIRROR_MAX_W-1:0] mirror(input logic [MIRROR_MAX_W-1:0] v,
                                                      input int w);
        logic [MIRROR_MAX_W-1:0] r;
        logic [MIRROR_MAX_W-1:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < MIRROR_MAX_W; i++) begin
            if (i < w) begin
                r = {r[MIRROR_MAX_W-2:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pad_stream_ser.sv
// Outbound serialiser: holds one internal word and walks its slices onto the
// pad bus, LSB slice first, reloading on the last beat so words stream gap-free.
//
// state  | meaning
// S_IDLE | no word held, s_ready high
// S_SEND | word held, driving slice bo on the pads
module pad_stream_ser
    import pad_stream_pkg::*;
#(
    parameter int PIN_OUT_W   = DEF_PIN_OUT_W,
    parameter int WORD_OUT_W  = DEF_WORD_OUT_W,
    parameter bit OUT_REVERSE = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic [WORD_OUT_W-1:0] s_data,
    output logic                  pad_out_valid,
    input  logic                  pad_out_ready,
    output logic                  pad_out_last,
    output logic [PIN_OUT_W-1:0]  pad_out_data
);

    localparam int RO  = WORD_OUT_W / PIN_OUT_W;
    localparam int BOW = clog2_safe(RO);

    ser_state_t            state, state_nxt;
    logic [BOW-1:0]        bo;
    logic [WORD_OUT_W-1:0] word;
    logic                  last_q;
    logic                  last_beat;
    logic                  s_fire;
    logic                  po_fire;
    logic [PIN_OUT_W-1:0]  slice;

    assign last_beat = (bo == BOW'(RO - 1));
    assign slice     = PIN_OUT_W'(word >> (bo * PIN_OUT_W));
    assign s_fire    = s_valid && s_ready;
    assign po_fire   = pad_out_valid && pad_out_ready;

    always_comb begin
        pad_out_data = slice;
        if (OUT_REVERSE)
            pad_out_data = PIN_OUT_W'(mirror(MIRROR_MAX_W'(slice), PIN_OUT_W));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        s_ready       = 1'b1;
        pad_out_valid = 1'b0;
        pad_out_last  = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_valid)
                    state_nxt = S_SEND;
            end
            S_SEND: begin
                pad_out_valid = 1'b1;
                pad_out_last  = last_q && last_beat;
                // Accepting on the final beat's handshake avoids an idle cycle.
                s_ready       = pad_out_ready && last_beat;
                if (pad_out_ready && last_beat && !s_valid)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bo     <= '0;
            word   <= '0;
            last_q <= 1'b0;
        end else begin
            if (po_fire)
                bo <= last_beat ? '0 : bo + BOW'(1);
            if (s_fire) begin
                word   <= s_data;
                last_q <= s_last;
            end
        end
    end

endmodule

// File: rtl/pad_stream_bridge.sv
// Pad bus bridge: packs the narrow inbound pad stream into internal words and
// serialises internal words onto the outbound pads, counting packets each way.
module pad_stream_bridge
    import pad_stream_pkg::*;
#(
    parameter int PIN_IN_W    = DEF_PIN_IN_W,
    parameter int WORD_IN_W   = DEF_WORD_IN_W,
    parameter int PIN_OUT_W   = DEF_PIN_OUT_W,
    parameter int WORD_OUT_W  = DEF_WORD_OUT_W,
    parameter bit IN_REVERSE  = 1'b1,
    parameter bit OUT_REVERSE = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pad_in_valid,
    output logic                  pad_in_ready,
    input  logic                  pad_in_last,
    input  logic [PIN_IN_W-1:0]   pad_in_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [WORD_IN_W-1:0]  m_data,
    output logic [clog2_safe(WORD_IN_W/PIN_IN_W + 1)-1:0] m_beats,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic [WORD_OUT_W-1:0] s_data,
    output logic                  pad_out_valid,
    input  logic                  pad_out_ready,
    output logic                  pad_out_last,
    output logic [PIN_OUT_W-1:0]  pad_out_data,
    output logic [15:0]           rx_pkt_cnt,
    output logic [15:0]           tx_pkt_cnt
);

    localparam int RI  = WORD_IN_W / PIN_IN_W;
    localparam int BIW = clog2_safe(RI);
    localparam int BW  = clog2_safe(RI + 1);

    logic [BIW-1:0]       bi;
    logic [WORD_IN_W-1:0] acc;
    logic [WORD_IN_W-1:0] word_nxt;
    logic [PIN_IN_W-1:0]  beat;
    logic                 in_fire;
    logic                 in_close;
    logic                 m_fire;
    logic                 out_fire;

    always_comb begin
        beat = pad_in_data;
        if (IN_REVERSE)
            beat = PIN_IN_W'(mirror(MIRROR_MAX_W'(pad_in_data), PIN_IN_W));
    end

    // Combinational from m_ready so a full-rate stream never bubbles.
    assign pad_in_ready = !m_valid || m_ready;
    assign in_fire      = pad_in_valid && pad_in_ready;
    assign in_close     = (bi == BIW'(RI - 1)) || pad_in_last;
    assign m_fire       = m_valid && m_ready;
    assign out_fire     = pad_out_valid && pad_out_ready;
    assign word_nxt     = acc | (WORD_IN_W'(beat) << (bi * PIN_IN_W));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bi      <= '0;
            acc     <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            m_beats <= '0;
        end else begin
            if (m_fire)
                m_valid <= 1'b0;
            if (in_fire) begin
                if (in_close) begin
                    // acc is cleared on every close, so unfilled slices stay zero.
                    m_data  <= word_nxt;
                    m_beats <= BW'(bi) + BW'(1);
                    m_last  <= pad_in_last;
                    m_valid <= 1'b1;
                    bi      <= '0;
                    acc     <= '0;
                end else begin
                    acc <= word_nxt;
                    bi  <= bi + BIW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_pkt_cnt <= '0;
            tx_pkt_cnt <= '0;
        end else begin
            if (m_fire && m_last)
                rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
            if (out_fire && pad_out_last)
                tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
        end
    end

    pad_stream_ser #(
        .PIN_OUT_W   (PIN_OUT_W),
        .WORD_OUT_W  (WORD_OUT_W),
        .OUT_REVERSE (OUT_REVERSE)
    ) u_ser (
        .clock         (clock),
        .reset         (reset),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_last        (s_last),
        .s_data        (s_data),
        .pad_out_valid (pad_out_valid),
        .pad_out_ready (pad_out_ready),
        .pad_out_last  (pad_out_last),
        .pad_out_data  (pad_out_data)
    );

endmodule

// File: tb/tb_pad_stream_bridge.sv
// Bench for pad_stream_bridge: a plain instance and a fully bit-reversing
// instance share stimulus and are scored against a packet-level model.
module tb_pad_stream_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        pad_in_valid, pad_in_last;
    logic [7:0]  pad_in_data;
    logic        m_ready;
    logic        s_valid, s_last;
    logic [31:0] s_data;
    logic        pad_out_ready;

    logic        pad_in_ready, m_valid, m_last, s_ready, pad_out_valid, pad_out_last;
    logic [31:0] m_data;
    logic [2:0]  m_beats;
    logic [15:0] pad_out_data, rx_pkt_cnt, tx_pkt_cnt;

    logic        pad_in_ready_r, m_valid_r, m_last_r, s_ready_r, pad_out_valid_r, pad_out_last_r;
    logic [31:0] m_data_r;
    logic [2:0]  m_beats_r;
    logic [15:0] pad_out_data_r, rx_pkt_cnt_r, tx_pkt_cnt_r;

    always #5 clock = ~clock;

    pad_stream_bridge #(.IN_REVERSE(1'b0), .OUT_REVERSE(1'b0)) dut (
        .clock(clock), .reset(reset),
        .pad_in_valid(pad_in_valid), .pad_in_ready(pad_in_ready), .pad_in_last(pad_in_last),
        .pad_in_data(pad_in_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data), .m_beats(m_beats),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
        .pad_out_valid(pad_out_valid), .pad_out_ready(pad_out_ready), .pad_out_last(pad_out_last),
        .pad_out_data(pad_out_data),
        .rx_pkt_cnt(rx_pkt_cnt), .tx_pkt_cnt(tx_pkt_cnt)
    );

    pad_stream_bridge #(.IN_REVERSE(1'b1), .OUT_REVERSE(1'b1)) dut_r (
        .clock(clock), .reset(reset),
        .pad_in_valid(pad_in_valid), .pad_in_ready(pad_in_ready_r), .pad_in_last(pad_in_last),
        .pad_in_data(pad_in_data),
        .m_valid(m_valid_r), .m_ready(m_ready), .m_last(m_last_r), .m_data(m_data_r),
        .m_beats(m_beats_r),
        .s_valid(s_valid), .s_ready(s_ready_r), .s_last(s_last), .s_data(s_data),
        .pad_out_valid(pad_out_valid_r), .pad_out_ready(pad_out_ready),
        .pad_out_last(pad_out_last_r), .pad_out_data(pad_out_data_r),
        .rx_pkt_cnt(rx_pkt_cnt_r), .tx_pkt_cnt(tx_pkt_cnt_r)
    );

    typedef struct { logic [31:0] d; logic [2:0] beats; logic last; } in_word_t;
    typedef struct { logic [15:0] d; logic last; } out_beat_t;
    typedef struct { logic [7:0] b; logic last; } in_beat_t;
    typedef struct { logic [31:0] w; logic last; } out_word_t;

    in_word_t  exp_in[$], exp_in_r[$];
    out_beat_t exp_out[$], exp_out_r[$];
    in_beat_t  in_drv[$];
    out_word_t out_drv[$];
    logic [7:0] pkt_buf[$];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_rx   = 0;
    int exp_tx   = 0;
    bit rand_bp  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        r = {<<{v}};
        return r;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        r = {<<{v}};
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One packet from pkt_buf: split into 4-byte words, last on the final word.
    task automatic push_pkt();
        int n;
        n = pkt_buf.size();
        for (int i = 0; i < n; i += 4) begin
            in_word_t w, wr;
            int k;
            k = (n - i < 4) ? n - i : 4;
            w.d  = '0;
            wr.d = '0;
            for (int j = 0; j < k; j++) begin
                w.d  = w.d  | (32'(pkt_buf[i+j]) << (8 * j));
                wr.d = wr.d | (32'(rev8(pkt_buf[i+j])) << (8 * j));
                in_drv.push_back('{b: pkt_buf[i+j], last: (i + j == n - 1)});
            end
            w.beats  = 3'(k);
            w.last   = (i + k == n);
            wr.beats = w.beats;
            wr.last  = w.last;
            exp_in.push_back(w);
            exp_in_r.push_back(wr);
        end
        exp_rx++;
        pkt_buf.delete();
    endtask

    task automatic push_word(input logic [31:0] w, input logic l);
        out_drv.push_back('{w: w, last: l});
        exp_out.push_back('{d: w[15:0], last: 1'b0});
        exp_out.push_back('{d: w[31:16], last: l});
        exp_out_r.push_back('{d: rev16(w[15:0]), last: 1'b0});
        exp_out_r.push_back('{d: rev16(w[31:16]), last: l});
        if (l) exp_tx++;
    endtask

    task automatic drive_in(input int gap);
        while (in_drv.size() != 0) begin
            in_beat_t bt;
            int t;
            bt = in_drv.pop_front();
            t  = 0;
            repeat ($urandom_range(0, gap)) step();
            pad_in_valid = 1'b1;
            pad_in_data  = bt.b;
            pad_in_last  = bt.last;
            @(negedge clock);
            while (!pad_in_ready && t < 1000) begin
                t++;
                @(negedge clock);
            end
            if (t >= 1000) chk("in_ready_timeout", pad_in_ready, 1);
            step();
            pad_in_valid = 1'b0;
            pad_in_last  = 1'b0;
        end
    endtask

    task automatic drive_out(input int gap);
        while (out_drv.size() != 0) begin
            out_word_t ow;
            int t;
            ow = out_drv.pop_front();
            t  = 0;
            repeat ($urandom_range(0, gap)) step();
            s_valid = 1'b1;
            s_data  = ow.w;
            s_last  = ow.last;
            @(negedge clock);
            while (!s_ready && t < 1000) begin
                t++;
                @(negedge clock);
            end
            if (t >= 1000) chk("s_ready_timeout", s_ready, 1);
            step();
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_in.size() + exp_in_r.size() + exp_out.size() + exp_out_r.size()) != 0
               && t < 5000) begin
            @(negedge clock);
            t++;
        end
        chk("drain_left", exp_in.size() + exp_in_r.size() + exp_out.size() + exp_out_r.size(), 0);
        step();
        step();
    endtask

    always begin
        @(posedge clock);
        #1;
        m_ready       = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        pad_out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    logic        st_m, st_mr, st_p, st_pr;
    logic [31:0] hd_m, hd_mr;
    logic [15:0] hd_p, hd_pr;

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            st_m = 1'b0; st_mr = 1'b0; st_p = 1'b0; st_pr = 1'b0;
        end else begin
            if (st_m)  begin chk("m_hold_valid", m_valid, 1);   chk("m_hold_data", m_data, hd_m); end
            if (st_mr) begin chk("mr_hold_valid", m_valid_r, 1); chk("mr_hold_data", m_data_r, hd_mr); end
            if (st_p)  begin chk("po_hold_valid", pad_out_valid, 1); chk("po_hold_data", pad_out_data, hd_p); end
            if (st_pr) begin chk("por_hold_valid", pad_out_valid_r, 1); chk("por_hold_data", pad_out_data_r, hd_pr); end

            if (m_valid && m_ready) begin
                chk("m_word_expected", exp_in.size() != 0, 1);
                if (exp_in.size() != 0) begin
                    in_word_t e;
                    e = exp_in.pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_beats", m_beats, e.beats);
                    chk("m_last", m_last, e.last);
                end
            end
            if (m_valid_r && m_ready) begin
                chk("mr_word_expected", exp_in_r.size() != 0, 1);
                if (exp_in_r.size() != 0) begin
                    in_word_t e;
                    e = exp_in_r.pop_front();
                    chk("mr_data", m_data_r, e.d);
                    chk("mr_beats", m_beats_r, e.beats);
                    chk("mr_last", m_last_r, e.last);
                end
            end
            if (pad_out_valid && pad_out_ready) begin
                chk("po_beat_expected", exp_out.size() != 0, 1);
                if (exp_out.size() != 0) begin
                    out_beat_t e;
                    e = exp_out.pop_front();
                    chk("po_data", pad_out_data, e.d);
                    chk("po_last", pad_out_last, e.last);
                end
            end
            if (pad_out_valid_r && pad_out_ready) begin
                chk("por_beat_expected", exp_out_r.size() != 0, 1);
                if (exp_out_r.size() != 0) begin
                    out_beat_t e;
                    e = exp_out_r.pop_front();
                    chk("por_data", pad_out_data_r, e.d);
                    chk("por_last", pad_out_last_r, e.last);
                end
            end

            st_m  = m_valid && !m_ready;           hd_m  = m_data;
            st_mr = m_valid_r && !m_ready;         hd_mr = m_data_r;
            st_p  = pad_out_valid && !pad_out_ready;   hd_p  = pad_out_data;
            st_pr = pad_out_valid_r && !pad_out_ready; hd_pr = pad_out_data_r;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        int len;
        int cnt;
        reset = 1'b1;
        pad_in_valid = 1'b0; pad_in_last = 1'b0; pad_in_data = '0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        m_ready = 1'b1; pad_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        @(negedge clock);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_beats", m_beats, 0);
        chk("rst_po_valid", pad_out_valid, 0);
        chk("rst_po_last", pad_out_last, 0);
        chk("rst_po_data", pad_out_data, 0);
        chk("rst_rx_cnt", rx_pkt_cnt, 0);
        chk("rst_tx_cnt", tx_pkt_cnt, 0);
        chk("rst_pad_in_ready", pad_in_ready, 1);
        chk("rst_s_ready", s_ready, 1);
        step();

        for (int i = 1; i <= 8; i++) pkt_buf.push_back(8'(i));
        push_pkt();
        drive_in(0);
        drain();
        chk("rx_cnt_pkt1", rx_pkt_cnt, exp_rx);

        pkt_buf.push_back(8'hAA); pkt_buf.push_back(8'hBB); pkt_buf.push_back(8'hCC);
        push_pkt();
        drive_in(0);
        drain();

        repeat (4) pkt_buf.push_back(8'h01);
        push_pkt();
        drive_in(0);
        drain();
        chk("rx_cnt_directed", rx_pkt_cnt, exp_rx);
        chk("rxr_cnt_directed", rx_pkt_cnt_r, exp_rx);

        push_word(32'hDEADBEEF, 1'b1);
        drive_out(0);
        cnt = 0;
        @(negedge clock);
        while (!s_ready && cnt < 20) begin
            cnt++;
            @(negedge clock);
        end
        chk("s_ready_low_cycles", cnt, 1);
        drain();
        chk("tx_cnt_directed", tx_pkt_cnt, exp_tx);

        rand_bp = 1'b1;
        total = 0;
        while (total < 2048) begin
            len = $urandom_range(1, 12);
            if (total + len > 2048) len = 2048 - total;
            for (int j = 0; j < len; j++) pkt_buf.push_back(8'($urandom));
            total += len;
            push_pkt();
        end
        for (int i = 0; i < 768; i++) push_word($urandom, $urandom_range(0, 3) == 0);
        fork
            drive_in(3);
            drive_out(3);
        join
        drain();
        rand_bp = 1'b0;
        step();
        chk("rx_cnt_random", rx_pkt_cnt, exp_rx);
        chk("tx_cnt_random", tx_pkt_cnt, exp_tx);
        chk("rxr_cnt_random", rx_pkt_cnt_r, exp_rx);
        chk("txr_cnt_random", tx_pkt_cnt_r, exp_tx);

        // Two bytes of an unfinished word, then reset: they must vanish.
        in_drv.push_back('{b: 8'h5A, last: 1'b0});
        in_drv.push_back('{b: 8'hA5, last: 1'b0});
        drive_in(0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_rx = 0;
        exp_tx = 0;
        @(negedge clock);
        chk("post_rst_m_valid", m_valid, 0);
        chk("post_rst_rx_cnt", rx_pkt_cnt, 0);
        chk("post_rst_tx_cnt", tx_pkt_cnt, 0);
        step();
        pkt_buf.push_back(8'h11); pkt_buf.push_back(8'h22);
        pkt_buf.push_back(8'h33); pkt_buf.push_back(8'h44);
        push_pkt();
        drive_in(0);
        drain();
        chk("post_rst_rx_cnt_after_pkt", rx_pkt_cnt, exp_rx);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
